// File: rtl/fft8_ctrl.sv
// Sequencer for an 8-point radix-2 DIT FFT: issues 3 stages x 4 butterflies over an
// in-place sample RAM and emits the matching write-back delayed by the butterfly latency.
module fft8_ctrl #(
  parameter int unsigned BF_LAT = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_go,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_stage,
  output logic [2:0] o_rd_addr_a,
  output logic [2:0] o_rd_addr_b,
  output logic [1:0] o_tw_idx,
  output logic       o_bf_start,
  output logic       o_wr_en,
  output logic [2:0] o_wr_addr_a,
  output logic [2:0] o_wr_addr_b
);

  localparam int unsigned CntW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam logic [CntW-1:0] DrainLast = CntW'(BF_LAT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e          r_state;
  logic [1:0]      r_stage;
  logic [1:0]      r_k;
  logic [CntW-1:0] r_drain;
  logic            r_busy;
  logic            r_done;
  logic            r_bf_start;
  logic [2:0]      r_rd_a;
  logic [2:0]      r_rd_b;
  logic [1:0]      r_tw;
  logic [6:0]      r_wb_pipe [BF_LAT];

  logic [1:0] w_iss_stage;
  logic [1:0] w_iss_k;
  logic [2:0] w_a;
  logic [2:0] w_b;
  logic [1:0] w_tw;

  // Stage/butterfly pair that would be issued on the next cycle if the FSM issues.
  always_comb begin
    w_iss_stage = r_stage;
    w_iss_k     = r_k + 2'd1;
    case (r_state)
      StIdle: begin
        w_iss_stage = 2'd0;
        w_iss_k     = 2'd0;
      end
      StDrain: begin
        w_iss_stage = r_stage + 2'd1;
        w_iss_k     = 2'd0;
      end
      default: ;
    endcase
  end

  // a = grp*2*span + j, b = a + span, tw = j << (2-s), unrolled per stage.
  always_comb begin
    w_a  = 3'd0;
    w_b  = 3'd0;
    w_tw = 2'd0;
    case (w_iss_stage)
      2'd0: begin
        w_a = {w_iss_k, 1'b0};
        w_b = {w_iss_k, 1'b1};
      end
      2'd1: begin
        w_a  = {w_iss_k[1], 1'b0, w_iss_k[0]};
        w_b  = {w_iss_k[1], 1'b1, w_iss_k[0]};
        w_tw = {w_iss_k[0], 1'b0};
      end
      default: begin
        w_a  = {1'b0, w_iss_k};
        w_b  = {1'b1, w_iss_k};
        w_tw = w_iss_k;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_stage    <= 2'd0;
      r_k        <= 2'd0;
      r_drain    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bf_start <= 1'b0;
      r_rd_a     <= 3'd0;
      r_rd_b     <= 3'd0;
      r_tw       <= 2'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_go) begin
            r_state    <= StIssue;
            r_stage    <= 2'd0;
            r_k        <= 2'd0;
            r_busy     <= 1'b1;
            r_bf_start <= 1'b1;
            r_rd_a     <= w_a;
            r_rd_b     <= w_b;
            r_tw       <= w_tw;
          end
        end
        StIssue: begin
          if (r_k == 2'd3) begin
            r_state    <= StDrain;
            r_drain    <= '0;
            r_bf_start <= 1'b0;
            r_rd_a     <= 3'd0;
            r_rd_b     <= 3'd0;
            r_tw       <= 2'd0;
          end else begin
            r_k    <= r_k + 2'd1;
            r_rd_a <= w_a;
            r_rd_b <= w_b;
            r_tw   <= w_tw;
          end
        end
        StDrain: begin
          if (r_drain == DrainLast) begin
            if (r_stage != 2'd2) begin
              r_state    <= StIssue;
              r_stage    <= w_iss_stage;
              r_k        <= 2'd0;
              r_bf_start <= 1'b1;
              r_rd_a     <= w_a;
              r_rd_b     <= w_b;
              r_tw       <= w_tw;
            end else begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_stage <= 2'd0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Write-back shift pipeline: {start, a, b} delayed by exactly BF_LAT cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(BF_LAT); i++) begin
        r_wb_pipe[i] <= 7'd0;
      end
    end else begin
      r_wb_pipe[0] <= {r_bf_start, r_rd_a, r_rd_b};
      for (int i = 1; i < int'(BF_LAT); i++) begin
        r_wb_pipe[i] <= r_wb_pipe[i-1];
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_stage     = r_stage;
  assign o_rd_addr_a = r_rd_a;
  assign o_rd_addr_b = r_rd_b;
  assign o_tw_idx    = r_tw;
  assign o_bf_start  = r_bf_start;
  assign o_wr_en     = r_wb_pipe[BF_LAT-1][6];
  assign o_wr_addr_a = r_wb_pipe[BF_LAT-1][5:3];
  assign o_wr_addr_b = r_wb_pipe[BF_LAT-1][2:0];

endmodule

// File: tb/tb_fft8_ctrl.sv
// Bench for fft8_ctrl: cycle-exact schedule check against a pair table and write-back
// scoreboard, butterfly/RAM end-to-end model, go-hold, mid-run reset and a BF_LAT=2 build.
module tb_fft8_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go  = 1'b0;
  logic sel = 1'b0;
  logic model_en = 1'b0;

  always #5 clk = ~clk;

  logic       d1_busy, d1_done, d1_bf, d1_we;
  logic [1:0] d1_stage, d1_tw;
  logic [2:0] d1_ra, d1_rb, d1_wa, d1_wb;
  logic       d2_busy, d2_done, d2_bf, d2_we;
  logic [1:0] d2_stage, d2_tw;
  logic [2:0] d2_ra, d2_rb, d2_wa, d2_wb;

  fft8_ctrl #(.BF_LAT(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_go(go && !sel),
    .o_busy(d1_busy), .o_done(d1_done), .o_stage(d1_stage),
    .o_rd_addr_a(d1_ra), .o_rd_addr_b(d1_rb), .o_tw_idx(d1_tw), .o_bf_start(d1_bf),
    .o_wr_en(d1_we), .o_wr_addr_a(d1_wa), .o_wr_addr_b(d1_wb)
  );

  fft8_ctrl #(.BF_LAT(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_go(go && sel),
    .o_busy(d2_busy), .o_done(d2_done), .o_stage(d2_stage),
    .o_rd_addr_a(d2_ra), .o_rd_addr_b(d2_rb), .o_tw_idx(d2_tw), .o_bf_start(d2_bf),
    .o_wr_en(d2_we), .o_wr_addr_a(d2_wa), .o_wr_addr_b(d2_wb)
  );

  logic       w_busy, w_done, w_bf, w_we;
  logic [1:0] w_stage, w_tw;
  logic [2:0] w_ra, w_rb, w_wa, w_wb;

  assign w_busy  = sel ? d2_busy  : d1_busy;
  assign w_done  = sel ? d2_done  : d1_done;
  assign w_bf    = sel ? d2_bf    : d1_bf;
  assign w_we    = sel ? d2_we    : d1_we;
  assign w_stage = sel ? d2_stage : d1_stage;
  assign w_tw    = sel ? d2_tw    : d1_tw;
  assign w_ra    = sel ? d2_ra    : d1_ra;
  assign w_rb    = sel ? d2_rb    : d1_rb;
  assign w_wa    = sel ? d2_wa    : d1_wa;
  assign w_wb    = sel ? d2_wb    : d1_wb;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] s;
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tw;
  } vec_t;
  vec_t vt [12];

  typedef struct {
    int         due;
    logic [2:0] a;
    logic [2:0] b;
  } wb_t;
  wb_t sbq [$];

  typedef struct {
    int y1r, y1i, y2r, y2i;
  } bf_t;
  bf_t bfq [$];

  int ram_re [8];
  int ram_im [8];
  int tw_re [4] = '{256, 181, 0, -181};
  int tw_im [4] = '{0, -181, -256, -181};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Butterfly + RAM model: reads at issue, writes results when the DUT strobes wr_en.
  always @(posedge clk) begin
    if (model_en) begin
      if (w_bf) begin
        bf_t r;
        int  pr, pi, k;
        k  = int'(w_tw);
        pr = (ram_re[w_rb] * tw_re[k] - ram_im[w_rb] * tw_im[k]) >>> 8;
        pi = (ram_re[w_rb] * tw_im[k] + ram_im[w_rb] * tw_re[k]) >>> 8;
        r.y1r = ram_re[w_ra] + pr;
        r.y1i = ram_im[w_ra] + pi;
        r.y2r = ram_re[w_ra] - pr;
        r.y2i = ram_im[w_ra] - pi;
        bfq.push_back(r);
      end
      if (w_we && bfq.size() > 0) begin
        bf_t r;
        r = bfq.pop_front();
        ram_re[w_wa] = r.y1r;
        ram_im[w_wa] = r.y1i;
        ram_re[w_wb] = r.y2r;
        ram_im[w_wb] = r.y2i;
      end
    end
  end

  // Caller sets go in cycle 0; checks cycles 1..3*(4+L)+1, optionally stopping at stop_at.
  task automatic run_xform(input int lat, input bit hold_go, input int stop_at);
    int per, last, s, pos, idx;
    bit exp_issue;
    wb_t e;
    per  = 4 + lat;
    last = 3 * per + 1;
    sbq.delete();
    for (int c = 1; c <= last; c++) begin
      tick();
      if (!hold_go) go = 1'b0;
      s   = (c - 1) / per;
      pos = (c - 1) % per;
      exp_issue = (c < last) && (pos < 4);
      chk("busy", 32'(w_busy), 32'(c < last));
      chk("done", 32'(w_done), 32'(c == last));
      chk("bf_start", 32'(w_bf), 32'(exp_issue));
      if (c < last) chk("stage", 32'(w_stage), 32'(s));
      if (exp_issue) begin
        idx = s * 4 + pos;
        chk("rd_a", 32'(w_ra), 32'(vt[idx].a));
        chk("rd_b", 32'(w_rb), 32'(vt[idx].b));
        chk("tw", 32'(w_tw), 32'(vt[idx].tw));
        e.due = c + lat;
        e.a   = vt[idx].a;
        e.b   = vt[idx].b;
        sbq.push_back(e);
      end else begin
        chk("rd_idle", 32'({w_ra, w_rb, w_tw}), 32'd0);
      end
      if (sbq.size() > 0 && sbq[0].due == c) begin
        e = sbq.pop_front();
        chk("wr_en", 32'(w_we), 32'd1);
        chk("wr_a", 32'(w_wa), 32'(e.a));
        chk("wr_b", 32'(w_wb), 32'(e.b));
      end else begin
        chk("wr_en_idle", 32'(w_we), 32'd0);
      end
      if (c == stop_at) return;
    end
    chk("sb_empty", 32'(sbq.size()), 32'd0);
  endtask

  task automatic load_ram(input int x0, input int xo);
    logic [2:0] n, r;
    for (int i = 0; i < 8; i++) begin
      n = 3'(i);
      r = {n[0], n[1], n[2]};
      ram_re[r] = (i == 0) ? x0 : xo;
      ram_im[r] = 0;
    end
    bfq.delete();
  endtask

  logic [21:0] all_out;
  assign all_out = {w_busy, w_done, w_stage, w_ra, w_rb, w_tw, w_bf, w_we, w_wa, w_wb};

  initial begin
    vt[0]  = '{2'd0, 3'd0, 3'd1, 2'd0};
    vt[1]  = '{2'd0, 3'd2, 3'd3, 2'd0};
    vt[2]  = '{2'd0, 3'd4, 3'd5, 2'd0};
    vt[3]  = '{2'd0, 3'd6, 3'd7, 2'd0};
    vt[4]  = '{2'd1, 3'd0, 3'd2, 2'd0};
    vt[5]  = '{2'd1, 3'd1, 3'd3, 2'd2};
    vt[6]  = '{2'd1, 3'd4, 3'd6, 2'd0};
    vt[7]  = '{2'd1, 3'd5, 3'd7, 2'd2};
    vt[8]  = '{2'd2, 3'd0, 3'd4, 2'd0};
    vt[9]  = '{2'd2, 3'd1, 3'd5, 2'd1};
    vt[10] = '{2'd2, 3'd2, 3'd6, 2'd2};
    vt[11] = '{2'd2, 3'd3, 3'd7, 2'd3};

    tick();
    tick();
    rst = 1'b0;

    // Idle hygiene on both builds
    for (int i = 0; i < 50; i++) begin
      tick();
      sel = 1'b0;
      #0 chk("idle1", 32'(all_out), 32'd0);
      sel = 1'b1;
      #0 chk("idle2", 32'(all_out), 32'd0);
    end
    sel = 1'b0;

    // Address/twiddle sequence, BF_LAT=1
    go = 1'b1;
    run_xform(1, 1'b0, 0);
    tick();
    chk("post_idle", 32'(all_out), 32'd0);

    // go held high: second transform starts in cycle 18
    tick();
    go = 1'b1;
    run_xform(1, 1'b1, 0);
    tick();
    chk("gap_busy", 32'(w_busy), 32'd0);
    chk("gap_bf", 32'(w_bf), 32'd0);
    chk("gap_done", 32'(w_done), 32'd0);
    run_xform(1, 1'b1, 0);
    go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("after_hold", 32'(all_out), 32'd0);
    end

    // Reset asserted in cycle 8
    go = 1'b1;
    run_xform(1, 1'b0, 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(w_busy), 32'd0);
    chk("rst_bf", 32'(w_bf), 32'd0);
    chk("rst_we", 32'(w_we), 32'd0);
    chk("rst_stage", 32'(w_stage), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_quiet", 32'(all_out), 32'd0);
    end
    go = 1'b1;
    run_xform(1, 1'b0, 0);
    tick();

    // End-to-end: impulse
    load_ram(256, 0);
    model_en = 1'b1;
    go = 1'b1;
    run_xform(1, 1'b0, 0);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("imp_re", 32'(ram_re[k]), 32'd256);
      chk("imp_im", 32'(ram_im[k]), 32'd0);
    end

    // End-to-end: constant
    load_ram(256, 256);
    go = 1'b1;
    run_xform(1, 1'b0, 0);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("dc_re", 32'(ram_re[k]), (k == 0) ? 32'd2048 : 32'd0);
      chk("dc_im", 32'(ram_im[k]), 32'd0);
    end
    model_en = 1'b0;

    // BF_LAT=2 build: 2-cycle drains, done in cycle 19
    sel = 1'b1;
    go  = 1'b1;
    run_xform(2, 1'b0, 0);
    tick();
    chk("lat2_post", 32'(all_out), 32'd0);
    sel = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fft8_ctrl.md
# fft8_ctrl

Sequencer for the 8-point radix-2 DIT FFT. It drives the shared butterfly unit through 3 stages × 4 butterflies over an in-place 8-entry complex sample memory. Each cycle it issues read addresses, a twiddle index and the butterfly `start`, then generates the matching delayed write-back. It sits between the sample RAM / twiddle ROM and the butterfly, and answers to a top-level `go`/`done` handshake.

## Interface

Parameters:
- `BF_LAT`, default 1: cycles from `bf_start` sampled to butterfly outputs valid. This is also the write-back delay and the per-stage drain length.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `go`  in  1  start request; sampled only in IDLE.
- `busy`  out  1  high while a transform is in progress.
- `done`  out  1  one-cycle pulse after the last write-back.
- `stage`  out  2  current stage, 0..2.
- `rd_addr_a`  out  3  sample RAM read address, x1 operand.
- `rd_addr_b`  out  3  sample RAM read address, x2 operand.
- `tw_idx`  out  2  twiddle ROM index k, selecting W8^k.
- `bf_start`  out  1  butterfly `start`; high on each issue cycle.
- `wr_en`  out  1  write-back strobe for both RAM write ports.
- `wr_addr_a`  out  3  write address for y1.
- `wr_addr_b`  out  3  write address for y2.

## Operation

- The sample RAM is loaded in bit-reversed order before `go`. Loading is outside this block.
- RAM reads are combinational, and the butterfly registers its inputs.
- States:
  - IDLE → ISSUE on `go`; stage=0, k=0.
  - ISSUE: one butterfly per cycle, k=0..3; after k=3 → DRAIN.
  - DRAIN: BF_LAT cycles, no issue. Then, if stage<2, stage+1, k=0, → ISSUE; otherwise → DONE.
  - DONE: one cycle, then → IDLE.
- Address generation for stage s and butterfly k:
  - span = 1<<s; j = k & (span−1); grp = k>>s.
  - a = grp·2·span + j; b = a + span.
  - tw_idx = j << (2−s), 2-bit.
  - All arithmetic is unsigned 3-bit with no wrap; the indices never exceed 7.
- Resulting pairs/twiddles:
  - stage 0: (0,1)(2,3)(4,5)(6,7), all tw 0.
  - stage 1: (0,2)t0, (1,3)t2, (4,6)t0, (5,7)t2.
  - stage 2: (0,4)t0, (1,5)t1, (2,6)t2, (3,7)t3.
- Write-back:
  - `wr_en`, `wr_addr_a` and `wr_addr_b` are `bf_start`, `rd_addr_a` and `rd_addr_b` delayed by exactly BF_LAT cycles, through a shift pipeline.
  - y1 is written to a, y2 to b.
- Stage barrier: the DRAIN cycles guarantee the last write of stage s completes before the first read of stage s+1. There is no read/write overlap on the same address.
- When `bf_start`=0, the read addresses and `tw_idx` are held at 0.
- `go` is ignored in ISSUE, DRAIN and DONE; there is no queuing. A `go` asserted in the DONE cycle is not accepted; it must still be high in IDLE.

## Timing

- Reset: all outputs are 0 one cycle after `rst` is sampled high, the state is IDLE, and the write pipeline is flushed. Reset has priority over everything else.
- Reset mid-transform aborts with no further `wr_en`. RAM contents are then undefined.
- Cycle numbering with BF_LAT=1, taking cycle 0 as the cycle where `go` is sampled in IDLE:
  - `busy` rises in cycle 1.
  - Stage 0: issue cycles 1–4, writes 2–5.
  - Stage 1: issue 6–9, writes 7–10.
  - Stage 2: issue 11–14, writes 12–15.
  - `done` in cycle 16, with `busy` low.
  - The next `go` is accepted at the earliest in cycle 17.
- In general, latency from `go` to `done` is 3·(4+BF_LAT)+1 cycles.
- `busy` is high in ISSUE and DRAIN, and low in IDLE and DONE.
- `stage` updates on the first issue cycle of each stage and holds through its drain.
- `done` and `bf_start` are never high together.

## Test plan

- **Address/twiddle sequence:**
  - Stimulus: `rst` then `go` one cycle.
  - Required: `bf_start` high in exactly cycles 1–4, 6–9 and 11–14, with (a,b,tw) matching the listed pairs.
  - Required: `wr_en` in cycles 2–5, 7–10 and 12–15, carrying the same addresses one cycle later.
  - Required: `done` in cycle 16.
- **End-to-end with butterfly and RAM models:**
  - Stimulus: impulse x[0]=256, others 0, loaded bit-reversed.
  - Required: all 8 bins equal 256+0j.
  - Stimulus: x[n]=256 for all n.
  - Required: X[0]=2048, others 0.
- **`go` while busy:**
  - Stimulus: hold `go` high continuously.
  - Required: transforms start at cycles 1 and 18. There are no extra issues, and `done` fires at cycles 16 and 33.
- **Reset mid-operation:**
  - Stimulus: `rst` in cycle 8.
  - Required: cycle 9 has `busy`, `bf_start` and `wr_en` all 0 and `stage`=0. A later `go` restarts cleanly at stage 0.
- **BF_LAT=2 build:**
  - Required: `wr_en` trails `bf_start` by 2 cycles.
  - Required: drains are 2 cycles and `done` falls in cycle 19.
- **Idle hygiene:**
  - Stimulus: no `go` for 50 cycles after reset.
  - Required: all outputs stay 0.
